// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants and types for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned HOLD_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage : arb_pkg

// File: rtl/rr_arbiter_8_pick.sv
// Combinational round-robin pick: rotate by ptr, take lowest set bit, rotate back.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick_onehot,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_any
);

  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [IDX_W-1:0]   rot_idx;

  // Bit k of rotated is requester (ptr + k) mod 8, so bit 0 is highest priority.
  assign doubled = {req, req} >> ptr;
  assign rotated = doubled[N_REQ-1:0];

  always_comb begin
    rot_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        rot_idx = IDX_W'(i);
      end
    end
  end

  assign pick_any    = |req;
  assign pick_idx    = pick_any ? IDX_W'(rot_idx + ptr) : '0;
  assign pick_onehot = pick_any ? (N_REQ'(1) << pick_idx) : '0;

endmodule : rr_pick8

// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with registered grant and programmable hold timeout.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic              TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0]  gnt_d;
  logic [IDX_W-1:0]  gnt_idx_d;
  logic              gnt_valid_d;
  logic              timeout_d;

  logic [N_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  rr_pick8 u_pick (
    .req         (req),
    .ptr         (ptr_q),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx),
    .pick_any    (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt       <= gnt_d;
      gnt_idx   <= gnt_idx_d;
      gnt_valid <= gnt_valid_d;
      timeout   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    gnt_d       = gnt;
    gnt_idx_d   = gnt_idx;
    gnt_valid_d = gnt_valid;
    timeout_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable && pick_any) begin
          gnt_d       = pick_onehot;
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          hold_d      = '0;
          state_d     = GRANT;
        end
      end

      GRANT: begin
        // A dropped request wins over a simultaneous timeout, so no pulse then.
        if (!req[gnt_idx] || (TIMEOUT_EN && hold_q == HOLD_LAST)) begin
          timeout_d   = req[gnt_idx];
          ptr_d       = IDX_W'(gnt_idx + IDX_W'(1));
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
          state_d     = IDLE;
        end else if (hold_q != '1) begin
          hold_d = HOLD_W'(hold_q + HOLD_W'(1));
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule : rr_arbiter_8

// File: tb/tb_rr_arbiter_8.sv
// Directed plus randomized checks of rr_arbiter_8 against an owner/pointer reference model.
module tb_rr_arbiter_8;

  localparam int unsigned TB_MAX_HOLD = 4;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int tests;
  int fails;

  // Reference model: current owner (-1 = none), rotation pointer, cycles shown granted.
  int m_owner;
  int m_ptr;
  int m_shown;
  bit m_timeout;

  rr_arbiter_8 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", name, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic [7:0] r, input logic e, input logic rs);
    int idx;
    m_timeout = 1'b0;
    if (rs) begin
      m_owner = -1;
      m_ptr   = 0;
      m_shown = 0;
    end else if (m_owner < 0) begin
      if (e && r != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          idx = (m_ptr + k) % 8;
          if (m_owner < 0 && r[idx]) m_owner = idx;
        end
        m_shown = 1;
      end
    end else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
    end else if (TB_MAX_HOLD != 0 && m_shown == int'(TB_MAX_HOLD)) begin
      m_timeout = 1'b1;
      m_ptr     = (m_owner + 1) % 8;
      m_owner   = -1;
    end else begin
      m_shown++;
    end
  endtask

  task automatic check_model();
    logic [7:0] exp_gnt;
    exp_gnt = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
    chk("gnt",       32'(gnt),       32'(exp_gnt));
    chk("gnt_idx",   32'(gnt_idx),   (m_owner < 0) ? 32'd0 : 32'(m_owner));
    chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    chk("timeout",   32'(timeout),   32'(m_timeout));
  endtask

  task automatic cyc(input logic [7:0] r, input logic e, input logic rs);
    req    = r;
    enable = e;
    rst    = rs;
    @(posedge clk);
    model_step(r, e, rs);
    #1;
    check_model();
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; enable = 1'b0; req = 8'h00;
    tests = 0; fails = 0;
    m_owner = -1; m_ptr = 0; m_shown = 0; m_timeout = 1'b0;

    // Reset for two cycles, then full request gives requester 0.
    cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b1);
    chk("reset_valid", 32'(gnt_valid), 32'd0);
    cyc(8'hFF, 1'b1, 1'b0);
    chk("first_gnt", 32'(gnt), 32'h01);

    // Rotation: owner drops its bit for one cycle, then everyone requests again.
    for (int i = 1; i <= 8; i++) begin
      cyc(8'hFF & ~8'(1 << ((i - 1) % 8)), 1'b1, 1'b0);
      chk("rot_gap", 32'(gnt_valid), 32'd0);
      cyc(8'hFF, 1'b1, 1'b0);
      chk("rot_idx", 32'(gnt_idx), 32'(i % 8));
    end
    cyc(8'h00, 1'b1, 1'b0);

    // Wrap-around from ptr = 7.
    cyc(8'h40, 1'b1, 1'b0);
    chk("wrap_g6", 32'(gnt_idx), 32'd6);
    cyc(8'h00, 1'b1, 1'b0);
    cyc(8'h05, 1'b1, 1'b0);
    chk("wrap_g0", 32'(gnt_idx), 32'd0);
    cyc(8'h04, 1'b1, 1'b0);
    cyc(8'h04, 1'b1, 1'b0);
    chk("wrap_g2", 32'(gnt_idx), 32'd2);
    cyc(8'h00, 1'b1, 1'b0);

    // Timeout: four granted cycles, one-cycle pulse, then re-grant to 3.
    for (int i = 0; i < 4; i++) begin
      cyc(8'h08, 1'b1, 1'b0);
      chk("to_held", 32'(gnt), 32'h08);
    end
    cyc(8'h08, 1'b1, 1'b0);
    chk("to_pulse", {31'd0, timeout}, 32'd1);
    chk("to_idle", {31'd0, gnt_valid}, 32'd0);
    cyc(8'h08, 1'b1, 1'b0);
    chk("to_regrant", 32'(gnt_idx), 32'd3);
    chk("to_single", {31'd0, timeout}, 32'd0);
    cyc(8'h00, 1'b1, 1'b0);

    // Enable gating.
    for (int i = 0; i < 5; i++) begin
      cyc(8'h10, 1'b0, 1'b0);
      chk("en_block", 32'(gnt), 32'h00);
    end
    cyc(8'h10, 1'b1, 1'b0);
    chk("en_grant", 32'(gnt), 32'h10);
    cyc(8'h10, 1'b0, 1'b0);
    chk("en_keep", 32'(gnt), 32'h10);
    cyc(8'h00, 1'b0, 1'b0);

    // Mid-grant reset restores ptr to 0.
    cyc(8'h20, 1'b1, 1'b0);
    chk("mr_g5", 32'(gnt_idx), 32'd5);
    cyc(8'h20, 1'b1, 1'b1);
    chk("mr_clear", 32'(gnt), 32'h00);
    chk("mr_no_to", {31'd0, timeout}, 32'd0);
    cyc(8'h21, 1'b1, 1'b0);
    chk("mr_g0", 32'(gnt_idx), 32'd0);
    cyc(8'h00, 1'b1, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] r;
      r = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 3) == 0 && m_owner >= 0) r[m_owner] = 1'b1;
      cyc(r, $urandom_range(0, 4) != 0, $urandom_range(0, 99) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_rr_arbiter_8
